fifo_rd_strm: RTL

FIFO_RD_STRM -- requirements
Module: fifo_rd_strm

---
 rtl/fifo_rd_strm.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_rd_strm.sv
// FIFO read-side streamer: issues pops against a fixed-latency FIFO read port and
// re-times the returned words onto a valid/ready output stream without loss.
module fifo_rd_strm #(
    parameter int unsigned DATW  = 8,
    parameter int unsigned DELAY = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rden,
    input  logic [DATW-1:0] rdata,
    input  logic            rempty,
    output logic            ovld,
    input  logic            ordy,
    output logic [DATW-1:0] odata,
    output logic [2:0]      olevel
);

    localparam int unsigned DEPTH = DELAY + 1;
    localparam int unsigned PTRW  = $clog2(DEPTH);

    logic [DELAY-1:0] r_shift;
    logic [PTRW-1:0]  r_wptr;
    logic [PTRW-1:0]  r_rptr;
    logic [2:0]       r_count;
    logic [DATW-1:0]  r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_inflight;
    logic [2:0]       w_level;
    logic [PTRW-1:0]  w_wptr_nxt;
    logic [PTRW-1:0]  w_rptr_nxt;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(DELAY); i++) begin
            w_inflight = w_inflight + {2'b00, r_shift[i]};
        end
    end

    always_comb begin
        w_push     = r_shift[DELAY-1];
        ovld       = (r_count != 3'd0);
        w_pop      = ovld & ordy;
        odata      = r_mem[r_rptr];
        w_level    = r_count + w_inflight;
        olevel     = w_level;
        // Slot reservation counts words still in flight; a pop this cycle frees one.
        rden       = !rst && !rempty && ((w_level - {2'b00, w_pop}) < 3'(DEPTH));
        w_wptr_nxt = (r_wptr == PTRW'(DEPTH - 1)) ? '0 : r_wptr + PTRW'(1);
        w_rptr_nxt = (r_rptr == PTRW'(DEPTH - 1)) ? '0 : r_rptr + PTRW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else begin
            r_shift[0] <= rden;
            for (int i = 1; i < int'(DELAY); i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= rdata;
            r_wptr        <= w_wptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= w_rptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
